trig_pulse_shaper: RTL and testbench
====================================

// Module: trig_pulse_shaper
// PURPOSE
//  Per-channel output pulse shaper downstream of the crossbar switch matrix; consumes its trig_out bus.
//  Each channel turns a rising edge into a fixed-width pulse with programmable width, holdoff and polarity.
//  Edges arriving during a pulse or holdoff are counted as dropped.
//  Outputs drive the front-panel trigger output buffers; config comes from an APB register block elsewhere.
// PARAMETERS
//  NUM_CHANNELS  14  channels (12 front-panel ports + 2 LA), one per crossbar output
//  CNT_WIDTH     16  width of pulse-width and holdoff counters, in clk cycles
//  DROP_WIDTH    16  width of per-channel saturating dropped-edge counter
// PORTS
//  clk           in   1                       crossbar clock; all logic is on this clock
//  rst_n         in   1                       asynchronous active-low reset
//  trig_in       in   NUM_CHANNELS            crossbar outputs, synchronous to clk
//  cfg_enable    in   NUM_CHANNELS            per-channel enable; 0 = idle, output at inactive level
//  cfg_invert    in   NUM_CHANNELS            1 = active-low output
//  cfg_width     in   NUM_CHANNELS*CNT_WIDTH  pulse width in cycles; 0 = transparent passthrough
//  cfg_holdoff   in   NUM_CHANNELS*CNT_WIDTH  dead time after pulse, in cycles; 0 = none
//  drop_clear    in   NUM_CHANNELS            1-cycle strobe, zeroes that channel's drop_count
//  trig_out      out  NUM_CHANNELS            shaped trigger outputs, registered
//  busy          out  NUM_CHANNELS            1 while channel is in PULSE or HOLDOFF
//  drop_count    out  NUM_CHANNELS*DROP_WIDTH saturating count of ignored rising edges
// BEHAVIOUR
//  - Reset: state=IDLE, counters=0, trig_prev=0, trig_out=0, busy=0, drop_count=0. Reset is async; it has priority over everything.
//  - Rising edge: trig_in[i]=1 this cycle and trig_prev[i]=0, where trig_prev is a 1-cycle delayed copy of trig_in.
//  - States per channel: IDLE, PULSE, HOLDOFF. The enum is pulse_state_t.
//  - IDLE: on enabled rising edge with cfg_width!=0, latch cnt=cfg_width-1 and the holdoff value, then go to PULSE.
//  - Latency: edge seen in cycle t -> trig_out active from cycle t+1 for exactly cfg_width cycles.
//  - PULSE: cnt decrements to 0. At 0, go to HOLDOFF (cnt=holdoff-1) if latched holdoff!=0, else go to IDLE.
//  - HOLDOFF: cnt decrements, then go to IDLE. An edge in the cycle that enters IDLE is ignored and counted.
//    An edge on the next cycle starts a new pulse.
//  - Config is sampled only when a pulse starts. Changes to width/holdoff mid-pulse do not affect the current pulse.
//  - Any rising edge while state!=IDLE and enabled: drop_count++, saturating at all-ones.
//    drop_clear wins over a same-cycle increment; result is 0.
//  - cfg_width==0: trig_out follows trig_in with 1-cycle delay. State stays IDLE, busy=0, no drops are counted.
//  - cfg_enable=0: next cycle forces IDLE and inactive output. This aborts any pulse or holdoff; edges are not counted.
//  - trig_out = registered (active ^ cfg_invert). Inactive level is cfg_invert, which takes effect 1 cycle after reset release.
//  - busy = (state!=IDLE), registered together with trig_out.
//  - Counter arithmetic is unsigned. cfg_width=all-ones gives a (2^CNT_WIDTH-1)-cycle pulse and never wraps.
// STRUCTURE
//  - Add to CrossbarTypes: pulse_state_t enum {IDLE, PULSE, HOLDOFF}, typedef pulsecnt_t logic[CNT_WIDTH-1:0].
//  - Sub-module trig_pulse_channel: one FSM, counter, edge detector and drop counter.
//    The top level only generates NUM_CHANNELS instances and slices the packed cfg buses.
// TESTING
//  - Reset mid-pulse: width=100, assert rst_n=0 at cycle 40 -> trig_out=0, busy=0 same cycle, no pulse after release.
//  - Basic: width=5, holdoff=0, one 1-cycle trig_in pulse at t -> trig_out high t+1..t+5, then busy=0 at t+6.
//  - Holdoff and drops: width=4, holdoff=10, edges at t, t+3, t+12 -> one pulse; drop_count=2;
//    an edge at t+16 starts a new pulse at t+17.
//  - Passthrough/invert: width=0, invert=1, a 3-cycle trig_in -> trig_out low for 3 cycles delayed by 1; busy stays 0.
//  - Saturation/clear: DROP_WIDTH=4, 20 edges during a long pulse -> drop_count=15;
//    drop_clear coincident with an edge -> 0.
//  - Enable abort / config isolation: width=50; change width to 2 at cycle 10 -> pulse still 50 cycles.
//    Drop cfg_enable at cycle 20 -> trig_out inactive at 21, IDLE.

Source files
------------

// File: rtl/trig_pulse_shaper_pkg.sv
// Shared types for the crossbar trigger output path: pulse shaper channel state
// and default counter widths.
package trig_pulse_shaper_pkg;

  localparam int DEF_NUM_CHANNELS = 14;
  localparam int DEF_CNT_WIDTH    = 16;
  localparam int DEF_DROP_WIDTH   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } pulse_state_t;

  typedef logic [DEF_CNT_WIDTH-1:0] pulsecnt_t;

endpackage

// File: rtl/trig_pulse_channel.sv
// One trigger output channel: rising-edge detector, pulse/holdoff FSM with a
// shared down-counter, and a saturating counter of edges ignored while busy.
module trig_pulse_channel
  import trig_pulse_shaper_pkg::*;
#(
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int DROP_WIDTH = DEF_DROP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trig_in,
  input  logic                  cfg_enable,
  input  logic                  cfg_invert,
  input  logic [CNT_WIDTH-1:0]  cfg_width,
  input  logic [CNT_WIDTH-1:0]  cfg_holdoff,
  input  logic                  drop_clear,
  output logic                  trig_out,
  output logic                  busy,
  output logic [DROP_WIDTH-1:0] drop_count
);

  typedef logic [CNT_WIDTH-1:0]  cnt_t;
  typedef logic [DROP_WIDTH-1:0] drop_t;

  localparam cnt_t  CNT_ONE  = cnt_t'(1);
  localparam drop_t DROP_ONE = drop_t'(1);

  pulse_state_t state, state_nxt;
  cnt_t         cnt, cnt_nxt;
  cnt_t         hold, hold_nxt;
  logic         trig_prev;
  logic         rise;
  logic         out_nxt;
  logic         busy_nxt;
  logic         drop_inc;

  assign rise     = trig_in & ~trig_prev;
  assign drop_inc = cfg_enable && (state != IDLE) && rise;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      hold     <= '0;
      trig_out <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hold     <= hold_nxt;
      trig_out <= out_nxt;
      busy     <= busy_nxt;
    end
  end

  // NOTE: every signal gets a default before the case so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_nxt  = hold;
    if (!cfg_enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          // Width and holdoff are captured here only; later cfg changes do
          // not disturb a pulse already in flight.
          if (rise && (cfg_width != '0)) begin
            state_nxt = PULSE;
            cnt_nxt   = cfg_width - CNT_ONE;
            hold_nxt  = cfg_holdoff;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            if (hold != '0) begin
              state_nxt = HOLDOFF;
              cnt_nxt   = hold - CNT_ONE;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        HOLDOFF: begin
          if (cnt == '0) state_nxt = IDLE;
          else           cnt_nxt   = cnt - CNT_ONE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are computed from the next state so they register in the same
  // cycle as the state they describe.
  always_comb begin
    busy_nxt = (state_nxt != IDLE);
    if (cfg_enable && (state == IDLE) && (cfg_width == '0)) begin
      out_nxt = trig_in ^ cfg_invert;
    end else begin
      out_nxt = (state_nxt == PULSE) ^ cfg_invert;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_prev  <= 1'b0;
      drop_count <= '0;
    end else begin
      trig_prev <= trig_in;
      if (drop_clear) begin
        drop_count <= '0;
      end else if (drop_inc && !(&drop_count)) begin
        drop_count <= drop_count + DROP_ONE;
      end
    end
  end

endmodule

// File: rtl/trig_pulse_shaper.sv
// Front-panel trigger output shaper: one pulse channel per crossbar output,
// with the packed configuration buses sliced per channel.
module trig_pulse_shaper
  import trig_pulse_shaper_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int CNT_WIDTH    = $bits(pulsecnt_t),
  parameter int DROP_WIDTH   = DEF_DROP_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CHANNELS-1:0]          trig_in,
  input  logic [NUM_CHANNELS-1:0]          cfg_enable,
  input  logic [NUM_CHANNELS-1:0]          cfg_invert,
  input  logic [NUM_CHANNELS*CNT_WIDTH-1:0] cfg_width,
  input  logic [NUM_CHANNELS*CNT_WIDTH-1:0] cfg_holdoff,
  input  logic [NUM_CHANNELS-1:0]          drop_clear,
  output logic [NUM_CHANNELS-1:0]          trig_out,
  output logic [NUM_CHANNELS-1:0]          busy,
  output logic [NUM_CHANNELS*DROP_WIDTH-1:0] drop_count
);

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    trig_pulse_channel #(
      .CNT_WIDTH  (CNT_WIDTH),
      .DROP_WIDTH (DROP_WIDTH)
    ) u_channel (
      .clk         (clk),
      .rst_n       (rst_n),
      .trig_in     (trig_in[i]),
      .cfg_enable  (cfg_enable[i]),
      .cfg_invert  (cfg_invert[i]),
      .cfg_width   (cfg_width[i*CNT_WIDTH +: CNT_WIDTH]),
      .cfg_holdoff (cfg_holdoff[i*CNT_WIDTH +: CNT_WIDTH]),
      .drop_clear  (drop_clear[i]),
      .trig_out    (trig_out[i]),
      .busy        (busy[i]),
      .drop_count  (drop_count[i*DROP_WIDTH +: DROP_WIDTH])
    );
  end

endmodule

// File: tb/tb_trig_pulse_shaper.sv
// Bench for trig_pulse_shaper: directed scenarios plus a randomized run checked
// against a model that tracks each channel's busy window as absolute cycle times.
module tb_trig_pulse_shaper;

  localparam int N    = 14;
  localparam int CW   = 16;
  localparam int DW   = 4;
  localparam int DMAX = (1 << DW) - 1;
  localparam logic [N-1:0] INV_PAT = 14'h2A5B;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      trig_in;
  logic [N-1:0]      cfg_enable;
  logic [N-1:0]      cfg_invert;
  logic [N*CW-1:0]   cfg_width;
  logic [N*CW-1:0]   cfg_holdoff;
  logic [N-1:0]      drop_clear;
  logic [N-1:0]      trig_out;
  logic [N-1:0]      busy;
  logic [N*DW-1:0]   drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  trig_pulse_shaper #(
    .NUM_CHANNELS (N),
    .CNT_WIDTH    (CW),
    .DROP_WIDTH   (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trig_in     (trig_in),
    .cfg_enable  (cfg_enable),
    .cfg_invert  (cfg_invert),
    .cfg_width   (cfg_width),
    .cfg_holdoff (cfg_holdoff),
    .drop_clear  (drop_clear),
    .trig_out    (trig_out),
    .busy        (busy),
    .drop_count  (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a channel is busy over [m_ws, m_he], pulsing over [m_ws, m_pe].
  longint       cyc = 0;
  longint       m_ws[N];
  longint       m_pe[N];
  longint       m_he[N];
  logic         m_prev[N];
  int           m_drop[N];
  logic [N-1:0]    exp_out_v;
  logic [N-1:0]    exp_busy_v;
  logic [N*DW-1:0] exp_drop_v;

  task automatic model_reset();
    for (int ch = 0; ch < N; ch++) begin
      m_ws[ch] = 1; m_pe[ch] = 0; m_he[ch] = 0;
      m_prev[ch] = 1'b0;
      m_drop[ch] = 0;
    end
    exp_out_v  = '0;
    exp_busy_v = '0;
    exp_drop_v = '0;
  endtask

  task automatic model_update();
    for (int ch = 0; ch < N; ch++) begin
      longint w, h;
      logic   edge_m, idle_m, inv, o;
      w      = longint'(cfg_width[ch*CW +: CW]);
      h      = longint'(cfg_holdoff[ch*CW +: CW]);
      inv    = cfg_invert[ch];
      edge_m = trig_in[ch] && !m_prev[ch];
      idle_m = !(cyc >= m_ws[ch] && cyc <= m_he[ch]);
      if (!cfg_enable[ch]) begin
        m_ws[ch] = 1; m_pe[ch] = 0; m_he[ch] = 0;
        o = inv;
      end else if (!idle_m) begin
        if (edge_m && m_drop[ch] < DMAX) m_drop[ch]++;
        o = (cyc + 1 >= m_ws[ch] && cyc + 1 <= m_pe[ch]) ^ inv;
      end else if (w == 0) begin
        o = trig_in[ch] ^ inv;
      end else if (edge_m) begin
        m_ws[ch] = cyc + 1;
        m_pe[ch] = cyc + w;
        m_he[ch] = cyc + w + h;
        o = ~inv;
      end else begin
        o = inv;
      end
      if (drop_clear[ch]) m_drop[ch] = 0;
      m_prev[ch] = trig_in[ch];
      exp_out_v[ch]  = o;
      exp_busy_v[ch] = (cyc + 1 >= m_ws[ch] && cyc + 1 <= m_he[ch]);
      exp_drop_v[ch*DW +: DW] = DW'(m_drop[ch]);
    end
    cyc++;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cfg(input int ch, input logic en, input logic inv,
                         input logic [CW-1:0] w, input logic [CW-1:0] h);
    cfg_enable[ch] = en;
    cfg_invert[ch] = inv;
    cfg_width[ch*CW +: CW]   = w;
    cfg_holdoff[ch*CW +: CW] = h;
  endtask

  task automatic test_reset();
    cfg_invert = INV_PAT;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (trig_out !== '0) begin n_fail++; $display("FAIL reset_out got %h want 0", trig_out); end
    n_checks++;
    if (busy !== '0) begin n_fail++; $display("FAIL reset_busy got %h want 0", busy); end
    n_checks++;
    if (drop_count !== '0) begin n_fail++; $display("FAIL reset_drop got %h want 0", drop_count); end
    model_reset();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (trig_out !== INV_PAT) begin n_fail++; $display("FAIL reset_inactive_level got %h want %h", trig_out, INV_PAT); end
    n_checks++;
    if (busy !== '0) begin n_fail++; $display("FAIL reset_release_busy got %h want 0", busy); end
    cfg_invert = '0;
    step();
  endtask

  task automatic test_basic();
    set_cfg(0, 1'b1, 1'b0, 16'd5, 16'd0);
    trig_in[0] = 1'b1;
    step();
    trig_in[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      n_checks++;
      if (trig_out[0] !== 1'b1 || busy[0] !== 1'b1) begin
        n_fail++; $display("FAIL basic_pulse t+%0d got out=%b busy=%b want 1 1", k, trig_out[0], busy[0]);
      end
      step();
    end
    n_checks++;
    if (trig_out[0] !== 1'b0 || busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL basic_end t+6 got out=%b busy=%b want 0 0", trig_out[0], busy[0]);
    end
    set_cfg(0, 1'b0, 1'b0, 16'd0, 16'd0);
    step();
  endtask

  task automatic test_holdoff_drops();
    logic eo, eb;
    set_cfg(1, 1'b1, 1'b0, 16'd4, 16'd10);
    for (int k = 0; k <= 20; k++) begin
      int c;
      trig_in[1] = (k == 0 || k == 3 || k == 12 || k == 16);
      step();
      c  = k + 1;
      eo = (c >= 1 && c <= 4) || (c >= 17 && c <= 20);
      eb = (c >= 1 && c <= 14) || (c >= 17);
      n_checks++;
      if (trig_out[1] !== eo || busy[1] !== eb) begin
        n_fail++; $display("FAIL holdoff t+%0d got out=%b busy=%b want %b %b", c, trig_out[1], busy[1], eo, eb);
      end
    end
    trig_in[1] = 1'b0;
    n_checks++;
    if (drop_count[1*DW +: DW] !== 4'd2) begin
      n_fail++; $display("FAIL holdoff_drops got %0d want 2", drop_count[1*DW +: DW]);
    end
    set_cfg(1, 1'b0, 1'b0, 16'd0, 16'd0);
    step();
  endtask

  task automatic test_passthrough_invert();
    set_cfg(2, 1'b1, 1'b1, 16'd0, 16'd0);
    step();
    n_checks++;
    if (trig_out[2] !== 1'b1) begin n_fail++; $display("FAIL pass_idle got %b want 1", trig_out[2]); end
    for (int k = 0; k <= 5; k++) begin
      logic eo;
      trig_in[2] = (k < 3);
      step();
      eo = !(k < 3);
      n_checks++;
      if (trig_out[2] !== eo || busy[2] !== 1'b0) begin
        n_fail++; $display("FAIL pass t+%0d got out=%b busy=%b want %b 0", k + 1, trig_out[2], busy[2], eo);
      end
    end
    n_checks++;
    if (drop_count[2*DW +: DW] !== 4'd0) begin
      n_fail++; $display("FAIL pass_drops got %0d want 0", drop_count[2*DW +: DW]);
    end
    set_cfg(2, 1'b0, 1'b0, 16'd0, 16'd0);
    step();
  endtask

  task automatic test_saturation_clear();
    set_cfg(3, 1'b1, 1'b0, 16'd200, 16'd0);
    for (int k = 0; k <= 40; k++) begin
      trig_in[3] = (k % 2 == 0);
      step();
    end
    trig_in[3] = 1'b0;
    step();
    n_checks++;
    if (drop_count[3*DW +: DW] !== 4'd15) begin
      n_fail++; $display("FAIL sat_count got %0d want 15", drop_count[3*DW +: DW]);
    end
    trig_in[3]    = 1'b1;
    drop_clear[3] = 1'b1;
    step();
    drop_clear[3] = 1'b0;
    trig_in[3]    = 1'b0;
    n_checks++;
    if (drop_count[3*DW +: DW] !== 4'd0) begin
      n_fail++; $display("FAIL clear_wins got %0d want 0", drop_count[3*DW +: DW]);
    end
    step();
    trig_in[3] = 1'b1;
    step();
    trig_in[3] = 1'b0;
    n_checks++;
    if (drop_count[3*DW +: DW] !== 4'd1 || busy[3] !== 1'b1) begin
      n_fail++; $display("FAIL count_after_clear got %0d busy=%b want 1 1", drop_count[3*DW +: DW], busy[3]);
    end
    set_cfg(3, 1'b0, 1'b0, 16'd0, 16'd0);
    step();
  endtask

  task automatic test_enable_abort();
    set_cfg(4, 1'b1, 1'b0, 16'd50, 16'd0);
    for (int k = 0; k <= 25; k++) begin
      logic e;
      trig_in[4] = (k == 0 || k == 22);
      if (k == 10) set_cfg(4, 1'b1, 1'b0, 16'd2, 16'd0);
      if (k == 20) set_cfg(4, 1'b0, 1'b0, 16'd2, 16'd0);
      step();
      e = (k + 1 <= 20);
      n_checks++;
      if (trig_out[4] !== e || busy[4] !== e) begin
        n_fail++; $display("FAIL abort t+%0d got out=%b busy=%b want %b %b", k + 1, trig_out[4], busy[4], e, e);
      end
    end
    trig_in[4] = 1'b0;
    n_checks++;
    if (drop_count[4*DW +: DW] !== 4'd0) begin
      n_fail++; $display("FAIL abort_drops got %0d want 0", drop_count[4*DW +: DW]);
    end
    step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      if (k % 150 == 0) begin
        for (int ch = 0; ch < N; ch++) begin
          int r;
          logic [CW-1:0] w;
          r = int'($urandom_range(0, 19));
          if (r < 3)        w = '0;
          else if (r == 19) w = '1;
          else              w = CW'($urandom_range(1, 10));
          set_cfg(ch, ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), w,
                  CW'($urandom_range(0, 6)));
        end
      end
      for (int ch = 0; ch < N; ch++) begin
        trig_in[ch]    = ($urandom_range(0, 99) < 35);
        drop_clear[ch] = ($urandom_range(0, 99) < 2);
      end
      step();
      n_checks++;
      if (trig_out !== exp_out_v) begin
        n_fail++; $display("FAIL rand_out cyc=%0d got %h want %h", cyc, trig_out, exp_out_v);
      end
      n_checks++;
      if (busy !== exp_busy_v) begin
        n_fail++; $display("FAIL rand_busy cyc=%0d got %h want %h", cyc, busy, exp_busy_v);
      end
      n_checks++;
      if (drop_count !== exp_drop_v) begin
        n_fail++; $display("FAIL rand_drop cyc=%0d got %h want %h", cyc, drop_count, exp_drop_v);
      end
    end
    trig_in    = '0;
    drop_clear = '0;
  endtask

  task automatic test_reset_mid_pulse();
    cfg_enable = '0;
    cfg_invert = '0;
    step();
    set_cfg(5, 1'b1, 1'b0, 16'd100, 16'd0);
    trig_in[5] = 1'b1;
    step();
    trig_in[5] = 1'b0;
    for (int k = 0; k < 39; k++) step();
    n_checks++;
    if (trig_out[5] !== 1'b1) begin n_fail++; $display("FAIL mid_pulse_before got %b want 1", trig_out[5]); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (trig_out !== '0 || busy !== '0) begin
      n_fail++; $display("FAIL async_reset got out=%h busy=%h want 0 0", trig_out, busy);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 110; k++) begin
      step();
      n_checks++;
      if (trig_out !== exp_out_v || busy[5] !== 1'b0 || trig_out[5] !== 1'b0) begin
        n_fail++; $display("FAIL post_reset k=%0d got out=%h busy=%h want %h busy5=0", k, trig_out, busy, exp_out_v);
      end
    end
    n_checks++;
    if (drop_count !== '0) begin n_fail++; $display("FAIL post_reset_drop got %h want 0", drop_count); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    trig_in     = '0;
    cfg_enable  = '0;
    cfg_invert  = '0;
    cfg_width   = '0;
    cfg_holdoff = '0;
    drop_clear  = '0;
    model_reset();
    test_reset();
    test_basic();
    test_holdoff_drops();
    test_passthrough_invert();
    test_saturation_clear();
    test_enable_abort();
    test_random();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
